// File: rtl/alu_op_sequencer.sv
// Command-issue stage in front of an N-bit combinational ALU: owns a 4-entry register file,
// registers operands onto the ALU, captures and writes back the result, and presents it downstream.
module alu_op_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_ld,
  input  logic [2:0]   in_op,
  input  logic [1:0]   in_rd,
  input  logic [1:0]   in_rs1,
  input  logic [1:0]   in_rs2,
  input  logic [N-1:0] in_imm,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [N-1:0] alu_o,
  input  logic         alu_co,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_carry,
  output logic         out_zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] rf_reg [4];
  logic [1:0]   rd_reg;
  logic         accept;
  logic         issue;
  logic         writeback;

  assign accept    = in_valid && (state_reg == IDLE);
  assign issue     = accept && !in_ld;
  assign writeback = (state_reg == EXEC);
  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (issue) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Loads (IDLE only) and write-back (EXEC only) can never coincide, so each entry has one writer at a time.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rf
      logic ld_we, wb_we;
      assign ld_we = accept && in_ld && (in_rd == 2'(gi));
      assign wb_we = writeback && (rd_reg == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rf_reg[gi] <= '0;
        else if (ld_we) rf_reg[gi] <= in_imm;
        else if (wb_we) rf_reg[gi] <= alu_o;
      end
    end
  endgenerate

  // Operands are sampled at accept, so the ALU sees the pre-write values even when rd aliases rs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rd_reg  <= '0;
    end else if (issue) begin
      alu_a   <= rf_reg[in_rs1];
      alu_b   <= rf_reg[in_rs2];
      alu_sel <= in_op;
      rd_reg  <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (writeback) begin
      out_valid <= 1'b1;
      out_data  <= alu_o;
      out_carry <= alu_co;
      out_zero  <= (alu_o == '0);
    end else if ((state_reg == RESP) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer: a behavioural ALU drives the DUT's ALU port
// and a register-array model predicts every result beat, flag and handshake.
module tb_alu_op_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_ld;
  logic [2:0]   in_op;
  logic [1:0]   in_rd, in_rs1, in_rs2;
  logic [N-1:0] in_imm;
  logic [N-1:0] alu_a, alu_b, alu_o;
  logic [2:0]   alu_sel;
  logic         alu_co;
  logic         out_valid, out_ready, out_carry, out_zero, busy;
  logic [N-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_beat = 0;
  logic [N-1:0] model_rf [4];

  alu_op_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_o(alu_o), .alu_co(alu_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {carry, result}: arithmetic in N+1 bits so the top bit is the carry/borrow.
  function automatic logic [N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (op)
      3'd0:    return ea + eb;
      3'd1:    return ea - eb;
      3'd2:    return ea + 1;
      3'd3:    return ea - 1;
      3'd4:    return {1'b0, a & b};
      3'd5:    return {1'b0, a | b};
      3'd6:    return {1'b0, a ^ b};
      default: return {1'b0, a - b};
    endcase
  endfunction

  always_comb {alu_co, alu_o} = alu_fn(alu_sel, alu_a, alu_b);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_load(input logic [1:0] rd, input logic [N-1:0] imm);
    check_val("ld_in_ready", in_ready, 1);
    in_valid = 1; in_ld = 1; in_rd = rd; in_imm = imm;
    in_op = 3'($urandom); in_rs1 = 2'($urandom); in_rs2 = 2'($urandom);
    out_ready = 1'($urandom);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    model_rf[rd] = imm;
    check_val("ld_no_beat", out_valid, 0);
    check_val("ld_busy", busy, 0);
    $display("load R%0d <= %0h", rd, imm);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input int hold);
    logic [N:0] exp;
    logic [N-1:0] a, b;
    a = model_rf[rs1];
    b = model_rf[rs2];
    exp = alu_fn(op, a, b);
    check_val("op_in_ready", in_ready, 1);
    in_valid = 1; in_ld = 0; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = N'($urandom); out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    check_val("exec_busy", busy, 1);
    check_val("exec_in_ready", in_ready, 0);
    check_val("exec_no_valid", out_valid, 0);
    check_val("alu_a", alu_a, a);
    check_val("alu_b", alu_b, b);
    check_val("alu_sel", alu_sel, op);
    @(negedge clk);
    check_val("resp_valid", out_valid, 1);
    check_val("out_data", out_data, exp[N-1:0]);
    check_val("out_carry", out_carry, exp[N]);
    check_val("out_zero", out_zero, (exp[N-1:0] == 0));
    last_beat = cyc;
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0]; in_ld = 1; in_rd = 2'($urandom); in_imm = N'($urandom);
      @(negedge clk);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_data", out_data, exp[N-1:0]);
      check_val("hold_carry", out_carry, exp[N]);
      check_val("hold_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check_val("done_valid", out_valid, 0);
    check_val("done_in_ready", in_ready, 1);
    model_rf[rd] = exp[N-1:0];
    $display("op %0d R%0d <= R%0d(%0h),R%0d(%0h) -> %0h c%0b hold %0d", op, rd, rs1, a, rs2, b,
             exp[N-1:0], exp[N], hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_valid"}, out_valid, 0);
    check_val({tag, "_alu_a"}, alu_a, 0);
    check_val({tag, "_alu_b"}, alu_b, 0);
    check_val({tag, "_alu_sel"}, alu_sel, 0);
    check_val({tag, "_data"}, {out_data, out_carry, out_zero}, 0);
  endtask

  initial begin
    int beat_prev;
    rst_n = 0; in_valid = 0; in_ld = 0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_imm = 0; out_ready = 0;
    for (int i = 0; i < 4; i++) model_rf[i] = '0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    do_load(1, 9);
    do_load(2, 8);
    do_op(0, 3, 1, 2, 0);
    check_val("add_9_8", out_data, 1);
    do_op(0, 0, 3, 0, 0);
    check_val("wb_r3", out_data, 1);
    do_op(1, 0, 2, 1, 0);
    do_op(1, 0, 1, 2, 0);
    do_load(0, 15);
    do_op(2, 0, 0, 0, 0);
    do_op(6, 1, 1, 1, 0);
    do_op(0, 3, 2, 3, 5);

    // Reset in the middle of EXEC aborts the command.
    in_valid = 1; in_ld = 0; in_op = 0; in_rd = 2; in_rs1 = 3; in_rs2 = 3;
    @(negedge clk);
    in_valid = 0;
    check_val("abort_exec_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) model_rf[i] = '0;
    repeat (3) begin
      @(negedge clk);
      check_val("abort_no_beat", out_valid, 0);
    end
    do_op(0, 0, 0, 0, 0);
    check_val("abort_zero", out_zero, 1);
    for (int r = 1; r < 4; r++) do_op(5, 0, 2'(r), 2'(r), 0);

    do_load(1, 3);
    beat_prev = -1;
    for (int k = 0; k < 3; k++) begin
      do_op(2, 1, 1, 1, 0);
      check_val("inr_chain", out_data, 4 + k);
      if (beat_prev >= 0) check_val("beat_spacing", last_beat - beat_prev, 3);
      beat_prev = last_beat;
    end

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0)
        do_load(2'($urandom), N'($urandom));
      else
        do_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-issue stage that sits directly upstream of the n-bit combinational ALU. It owns a 4-entry operand register file and accepts one command per valid/ready handshake: either an immediate load or an ALU operation. For an ALU operation it registers the operands and opcode onto the ALU inputs, captures the ALU result and carry one cycle later, writes the result back, and presents it with carry/zero flags on a valid/ready output port.

## Interface
- N, 4, datapath width; equal to the ALU width parameter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  stage can accept a command; high exactly when state is IDLE.
- in_ld  in  1  1 = load immediate, 0 = ALU operation.
- in_op  in  3  ALU opcode: 0 ADD, 1 SUB, 2 INR, 3 DCR, 4 AND, 5 OR, 6 XOR, 7 CMP.
- in_rd  in  2  destination register index.
- in_rs1  in  2  operand A register index.
- in_rs2  in  2  operand B register index.
- in_imm  in  N  immediate for loads.
- alu_a  out  N  registered operand A to ALU.
- alu_b  out  N  registered operand B to ALU.
- alu_sel  out  3  registered opcode to ALU.
- alu_o  in  N  ALU result.
- alu_co  in  1  ALU carry/borrow.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  N  result.
- out_carry  out  1  captured alu_co.
- out_zero  out  1  1 when out_data == 0.
- busy  out  1  state != IDLE.

## Operation
- Register file R0..R3, N bits each; written only by loads and ALU write-back.
- States: IDLE, EXEC, RESP.
- IDLE: accept on in_valid & in_ready.
  - in_ld=1: R[in_rd] <= in_imm; remain IDLE; no output beat.
  - in_ld=0: alu_a <= R[in_rs1], alu_b <= R[in_rs2], alu_sel <= in_op, latch in_rd; go to EXEC.
- EXEC (one cycle): ALU evaluates the registered inputs. At the closing edge: R[rd] <= alu_o; out_data <= alu_o, out_carry <= alu_co, out_zero <= (alu_o == 0); out_valid <= 1; go to RESP.
- RESP: hold out_* stable until out_ready=1; at that edge out_valid <= 0, go to IDLE.
- alu_a/alu_b/alu_sel hold their last values outside EXEC.
- Operands are read at accept time: a command whose rs equals the previous command's rd sees the written-back value. With rd == rs1 in one command, the old value is used and the new value is written.
- Carry semantics come from the ALU unchanged: SUB/DCR carry = borrow bit of the (N+1)-bit result; logic ops and CMP give 0.
- in_valid and command fields are ignored outside IDLE.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; R0..R3 = 0; alu_a = alu_b = 0; alu_sel = 0; out_valid = out_carry = 0; out_data = 0; out_zero = 0; busy = 0; in_ready = 1.
- Load: accepted at edge T0; the register is readable by a command accepted at T1.
- ALU op accepted at edge T0 -> EXEC during T0..T1 -> out_valid high from T1. With out_ready held high, handshake at T2 and in_ready high from T2. Peak throughput: one ALU op per 3 cycles, one load per cycle.
- Backpressure: out_valid stays high and out_* stay stable for any number of cycles with out_ready=0.
- out_ready high outside RESP has no effect.
- Reset asserted during EXEC or RESP aborts the command: no write-back, no output beat, all state returns to reset values.

## Test plan
- Reset, then load R1=9 and R2=8 on consecutive cycles; ADD rd=3, rs1=1, rs2=2 -> out_data=1, out_carry=1, out_zero=0; R3=1, confirmed by ADD rd=0, rs1=3, rs2=0 -> 1.
- Same registers, SUB rs1=2, rs2=1 -> out_data=4'hF, out_carry=1; SUB rs1=1, rs2=2 -> 1, carry 0.
- Load R0=15; INR rs1=0 -> out_data=0, out_carry=1, out_zero=1. XOR R1 with R1 -> 0, carry 0, zero 1.
- Hold out_ready=0 for 5 cycles during RESP while in_valid pulses with a load -> out_* stable, in_ready=0, load ignored; release -> single beat, then IDLE.
- Assert rst_n low mid-EXEC of ADD rd=2 -> out_valid never rises; all registers 0; next ADD R0+R0 -> 0, zero 1.
- Back-to-back ops with rd of op k equal to rs1 of op k+1: load R1=3, then INR rd=1 rs1=1 three times -> 4, 5, 6, each beat 3 cycles apart.
